// File: rtl/vga_frame_scanner.sv
// -----------------------------------------------------------------------------
// vga_frame_scanner
//
// Scans a (H_ACTIVE/2) x (V_ACTIVE/2) frame buffer out to a VGA display at
// H_ACTIVE x V_ACTIVE, doubling every pixel in both axes. The block produces
// the frame-buffer read address, registers the filtered pixel coming back
// from the RAM + filter path, and drives the DAC pins. Sync and blank are
// delayed by the same number of pixel ticks as the colour path, so all pins
// stay aligned.
//
// Ports:
//   clk            system clock (pixel rate is clk/2)
//   rst_n          asynchronous, active-low reset
//   filter_output  filtered pixel {R[29:20], G[19:10], B[9:0]}
//   fb_rdaddress   frame-buffer read address (held outside the active area)
//   fb_rden        read enable, high only for active-area reads
//   vga_r/g/b      8-bit colour, top 8 bits of each 10-bit channel
//   vga_hs/vga_vs  active-low syncs
//   vga_blank_n    low outside the visible area
//   vga_sync_n     tied low
//   vga_clk        pixel clock (the tick toggle register)
//   frame_start    one-clk strobe at the start of vertical blanking
// -----------------------------------------------------------------------------
module vga_frame_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [29:0]       filter_output,
    output logic [ADDR_W-1:0] fb_rdaddress,
    output logic              fb_rden,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              vga_clk,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Address register is stage 1, RAM + filter add RD_LATENCY ticks.
    localparam int PIPE_D  = RD_LATENCY + 1;

    localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]     V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]     H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]     V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0]     HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]     VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_ACTIVE / 2);

    logic              tick_reg;
    logic [HW-1:0]     h_cnt_reg;
    logic [VW-1:0]     v_cnt_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [PIPE_D-1:0] active_pipe_reg;
    logic [PIPE_D-1:0] hs_pipe_reg;
    logic [PIPE_D-1:0] vs_pipe_reg;

    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic              h_wrap;
    logic              v_wrap;
    logic [ADDR_W-1:0] addr_next;
    logic              delayed_active;

    // Only the top 8 bits of each channel reach the DAC.
    logic unused_filter_lsbs;
    assign unused_filter_lsbs = ^{filter_output[21:20], filter_output[11:10], filter_output[1:0]};

    assign active    = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
    assign hs_raw    = !((h_cnt_reg >= HS_START) && (h_cnt_reg <= HS_END));
    assign vs_raw    = !((v_cnt_reg >= VS_START) && (v_cnt_reg <= VS_END));
    assign h_wrap    = (h_cnt_reg == H_LAST);
    assign v_wrap    = (v_cnt_reg == V_LAST);
    // Each frame-buffer pixel covers two display columns: drop h bit 0.
    assign addr_next = row_base_reg + ADDR_W'(h_cnt_reg >> 1);

    assign delayed_active = active_pipe_reg[PIPE_D-1];

    assign vga_clk    = tick_reg;
    assign vga_sync_n = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg        <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            row_base_reg    <= '0;
            // Delay lines reset to "blank, sync inactive" so release never
            // produces a partial sync pulse.
            active_pipe_reg <= '0;
            hs_pipe_reg     <= '1;
            vs_pipe_reg     <= '1;
            fb_rdaddress    <= '0;
            fb_rden         <= 1'b0;
            vga_r           <= '0;
            vga_g           <= '0;
            vga_b           <= '0;
            vga_hs          <= 1'b1;
            vga_vs          <= 1'b1;
            vga_blank_n     <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            tick_reg    <= ~tick_reg;
            frame_start <= 1'b0;

            if (tick_reg) begin
                // Raster counters
                if (h_wrap) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + 1'b1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 1'b1;
                end

                // Row base advances once per pair of display lines, so the
                // address needs no multiplier.
                if (h_wrap) begin
                    if (v_wrap) begin
                        row_base_reg <= '0;
                    end else if (v_cnt_reg[0] && (v_cnt_reg < V_ACT_C)) begin
                        row_base_reg <= row_base_reg + ROW_STEP;
                    end
                end

                // Stage 1: frame-buffer read; address holds during blanking.
                if (active) begin
                    fb_rdaddress <= addr_next;
                    fb_rden      <= 1'b1;
                end else begin
                    fb_rden      <= 1'b0;
                end

                // Control delay lines track the address + RAM/filter path.
                active_pipe_reg <= PIPE_D'({active_pipe_reg, active});
                hs_pipe_reg     <= PIPE_D'({hs_pipe_reg, hs_raw});
                vs_pipe_reg     <= PIPE_D'({vs_pipe_reg, vs_raw});

                // Output register: colour forced to black outside the picture.
                vga_r       <= delayed_active ? filter_output[29:22] : 8'h00;
                vga_g       <= delayed_active ? filter_output[19:12] : 8'h00;
                vga_b       <= delayed_active ? filter_output[9:2]   : 8'h00;
                vga_blank_n <= delayed_active;
                vga_hs      <= hs_pipe_reg[PIPE_D-1];
                vga_vs      <= vs_pipe_reg[PIPE_D-1];

                // Last visible pixel of the frame: vertical blanking begins.
                frame_start <= (h_cnt_reg == H_ACT_LAST) && (v_cnt_reg == V_ACT_LAST);
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_scanner
//
// Directed bench for vga_frame_scanner on a reduced raster (24 x 14 ticks,
// 16 x 8 visible) so whole frames fit in a short run. A two-tick RAM model
// returns its address as data; the filter maps it to distinct per-channel
// patterns so channel slicing and alignment are both visible on the pins.
// -----------------------------------------------------------------------------
module tb_vga_frame_scanner;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int RDL = 2;
    localparam int D   = RDL + 1;
    localparam int AW  = 17;
    localparam int FRAME_TICKS = HT * VT;
    localparam int FRAME_CLK   = 2 * FRAME_TICKS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [29:0]   filter_output;
    logic [AW-1:0] fb_rdaddress;
    logic          fb_rden;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

    int checks   = 0;
    int failures = 0;

    logic          all_ones_mode = 1'b0;
    logic          tb_tick;
    int            tick_n;
    logic [AW-1:0] ram_q1, ram_q2;

    vga_frame_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .RD_LATENCY(RDL), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .filter_output(filter_output),
        .fb_rdaddress(fb_rdaddress),
        .fb_rden(fb_rden),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n),
        .vga_clk(vga_clk),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Bench-side tick count (ticks since reset release) and a RAM with two
    // ticks of read latency that returns data = address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_tick <= 1'b0;
            tick_n  <= 0;
            ram_q1  <= '0;
            ram_q2  <= '0;
        end else begin
            tb_tick <= ~tb_tick;
            if (tb_tick) begin
                tick_n <= tick_n + 1;
                ram_q1 <= fb_rdaddress;
                ram_q2 <= ram_q1;
            end
        end
    end

    always_comb begin
        if (all_ones_mode)
            filter_output = '1;
        else
            filter_output = {ram_q2[7:0], 2'b01, ~ram_q2[7:0], 2'b10, ram_q2[7:0] ^ 8'h5A, 2'b11};
    end

    // Raster position p = number of counter ticks consumed before this one.
    function automatic int pos_h(input int p);
        return p % HT;
    endfunction

    function automatic int pos_v(input int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit pos_active(input int p);
        return (p >= 0) && (pos_h(p) < HA) && (pos_v(p) < VA);
    endfunction

    function automatic int pix_addr(input int h, input int v);
        return (v / 2) * (HA / 2) + h / 2;
    endfunction

    // Address expected on fb_rdaddress after position p was consumed.
    function automatic int held_addr(input int p);
        int h, v;
        if (p < 0) return 0;
        h = pos_h(p);
        v = pos_v(p);
        if (v >= VA) return pix_addr(HA - 1, VA - 1);
        if (h >= HA) return pix_addr(HA - 1, v);
        return pix_addr(h, v);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({fb_rden, fb_rdaddress} !== {1'b0, 17'd0}) begin
            failures++;
            $display("FAIL reset_addr: got rden=%0b addr=%0d, expected rden=0 addr=0", fb_rden, fb_rdaddress);
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin
            failures++;
            $display("FAIL reset_colour: got %h/%h/%h, expected 00/00/00", vga_r, vga_g, vga_b);
        end
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_ctrl: got hs,vs,blank_n,sync_n,clk,fs=%b, expected 110000",
                     {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({vga_clk, fb_rden} !== 2'b10) begin
            failures++;
            $display("FAIL first_edge: got vga_clk=%0b rden=%0b, expected vga_clk=1 rden=0", vga_clk, fb_rden);
        end
        @(negedge clk);
        checks++;
        if ({vga_clk, fb_rden, fb_rdaddress} !== {1'b0, 1'b1, 17'd0}) begin
            failures++;
            $display("FAIL first_tick: got vga_clk=%0b rden=%0b addr=%0d, expected 0 1 0", vga_clk, fb_rden, fb_rdaddress);
        end
        $display("test_reset done: checks=%0d", checks);
    endtask

    task automatic test_address();
        int p_tab[10] = '{1, 2, 15, 16, 24, 47, 48, 50, 183, 200};
        int a_tab[10] = '{0, 1, 7, 7, 0, 7, 8, 9, 31, 31};
        bit r_tab[10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
        int p, hits, max_addr;
        bit exp_rden;
        hits = 0;
        max_addr = 0;
        for (int c = 0; c < 2 * (FRAME_TICKS + HT); c++) begin
            @(negedge clk);
            p = tick_n - 1;
            exp_rden = pos_active(p);
            checks++;
            if (fb_rden !== exp_rden || fb_rdaddress !== AW'(held_addr(p))) begin
                failures++;
                $display("FAIL addr_seq p=%0d: got rden=%0b addr=%0d, expected rden=%0b addr=%0d",
                         p, fb_rden, fb_rdaddress, exp_rden, held_addr(p));
            end
            if (!tb_tick) begin
                for (int k = 0; k < 10; k++) begin
                    if (p == p_tab[k]) begin
                        hits++;
                        checks++;
                        if (fb_rden !== r_tab[k] || fb_rdaddress !== AW'(a_tab[k])) begin
                            failures++;
                            $display("FAIL addr_vec p=%0d: got rden=%0b addr=%0d, expected rden=%0b addr=%0d",
                                     p, fb_rden, fb_rdaddress, r_tab[k], a_tab[k]);
                        end
                    end
                end
            end
            if (fb_rden === 1'b1 && int'(fb_rdaddress) > max_addr) max_addr = int'(fb_rdaddress);
        end
        checks++;
        if (hits !== 10) begin
            failures++;
            $display("FAIL addr_vec_hits: got %0d, expected 10", hits);
        end
        checks++;
        if (max_addr !== 31) begin
            failures++;
            $display("FAIL addr_max: got %0d, expected 31", max_addr);
        end
        $display("test_address done: checks=%0d", checks);
    endtask

    task automatic test_pixels();
        int q, h, v, a, n;
        logic eb, ehs, evs, efs;
        logic [7:0] er, eg, eblu;
        for (int c = 0; c < 2 * FRAME_CLK; c++) begin
            @(negedge clk);
            n = tick_n;
            q = n - 1 - D;
            h = (q >= 0) ? pos_h(q) : 0;
            v = (q >= 0) ? pos_v(q) : 0;
            eb  = pos_active(q);
            ehs = (q < 0) || !(h >= HA + HF && h < HA + HF + HS);
            evs = (q < 0) || !(v >= VA + VF && v < VA + VF + VS);
            a   = pix_addr(h, v);
            er   = eb ? 8'(a) : 8'h00;
            eg   = eb ? ~8'(a) : 8'h00;
            eblu = eb ? (8'(a) ^ 8'h5A) : 8'h00;
            efs = !tb_tick && (n >= 1) && (((n - 1) % FRAME_TICKS) == (VA - 1) * HT + HA - 1);
            checks++;
            if ({vga_r, vga_g, vga_b} !== {er, eg, eblu}) begin
                failures++;
                $display("FAIL pix_colour q=%0d: got %h/%h/%h, expected %h/%h/%h", q, vga_r, vga_g, vga_b, er, eg, eblu);
            end
            checks++;
            if ({vga_blank_n, vga_hs, vga_vs} !== {eb, ehs, evs}) begin
                failures++;
                $display("FAIL pix_ctrl q=%0d: got blank_n,hs,vs=%b, expected %b", q, {vga_blank_n, vga_hs, vga_vs}, {eb, ehs, evs});
            end
            checks++;
            if (frame_start !== efs) begin
                failures++;
                $display("FAIL frame_start n=%0d: got %0b, expected %0b", n, frame_start, efs);
            end
            checks++;
            if ({vga_clk, vga_sync_n} !== {tb_tick, 1'b0}) begin
                failures++;
                $display("FAIL clk_pins: got vga_clk=%0b sync_n=%0b, expected %0b 0", vga_clk, vga_sync_n, tb_tick);
            end
        end
        $display("test_pixels done: checks=%0d", checks);
    endtask

    task automatic test_sync_timing();
        int hs_fall, vs_fall, fs_rise, hs_n, vs_n, fs_n;
        logic hs_q, vs_q, fs_q;
        hs_fall = -1; vs_fall = -1; fs_rise = -1;
        hs_n = 0; vs_n = 0; fs_n = 0;
        @(negedge clk);
        hs_q = vga_hs; vs_q = vga_vs; fs_q = frame_start;
        for (int c = 0; c < 2 * FRAME_CLK + 200; c++) begin
            @(negedge clk);
            if (hs_q && !vga_hs) begin
                if (hs_fall >= 0) begin
                    checks++;
                    if (c - hs_fall !== 2 * HT) begin
                        failures++;
                        $display("FAIL hs_period: got %0d clk, expected %0d", c - hs_fall, 2 * HT);
                    end
                end
                hs_fall = c;
            end
            if (!hs_q && vga_hs && hs_fall >= 0) begin
                hs_n++;
                checks++;
                if (c - hs_fall !== 2 * HS) begin
                    failures++;
                    $display("FAIL hs_width: got %0d clk, expected %0d", c - hs_fall, 2 * HS);
                end
            end
            if (vs_q && !vga_vs) begin
                if (vs_fall >= 0) begin
                    checks++;
                    if (c - vs_fall !== FRAME_CLK) begin
                        failures++;
                        $display("FAIL vs_period: got %0d clk, expected %0d", c - vs_fall, FRAME_CLK);
                    end
                end
                vs_fall = c;
            end
            if (!vs_q && vga_vs && vs_fall >= 0) begin
                vs_n++;
                checks++;
                if (c - vs_fall !== 2 * HT * VS) begin
                    failures++;
                    $display("FAIL vs_width: got %0d clk, expected %0d", c - vs_fall, 2 * HT * VS);
                end
            end
            if (!fs_q && frame_start) begin
                if (fs_rise >= 0) begin
                    checks++;
                    if (c - fs_rise !== FRAME_CLK) begin
                        failures++;
                        $display("FAIL fs_period: got %0d clk, expected %0d", c - fs_rise, FRAME_CLK);
                    end
                end
                fs_rise = c;
                fs_n++;
            end
            if (fs_q && !frame_start) begin
                checks++;
                if (c - fs_rise !== 1) begin
                    failures++;
                    $display("FAIL fs_width: got %0d clk, expected 1", c - fs_rise);
                end
            end
            hs_q = vga_hs; vs_q = vga_vs; fs_q = frame_start;
        end
        checks++;
        if (hs_n < 2 * VT || vs_n < 2 || fs_n < 2) begin
            failures++;
            $display("FAIL sync_pulse_count: got hs=%0d vs=%0d fs=%0d, expected at least %0d/2/2", hs_n, vs_n, fs_n, 2 * VT);
        end
        $display("test_sync_timing done: checks=%0d", checks);
    endtask

    task automatic test_blank_forcing();
        int q, white;
        logic eb;
        logic [7:0] ec;
        white = 0;
        all_ones_mode = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < FRAME_CLK; c++) begin
            @(negedge clk);
            q  = tick_n - 1 - D;
            eb = pos_active(q);
            ec = eb ? 8'hFF : 8'h00;
            checks++;
            if ({vga_blank_n, vga_r, vga_g, vga_b} !== {eb, ec, ec, ec}) begin
                failures++;
                $display("FAIL blank_force q=%0d: got blank_n=%0b %h/%h/%h, expected blank_n=%0b %h/%h/%h",
                         q, vga_blank_n, vga_r, vga_g, vga_b, eb, ec, ec, ec);
            end
            if (vga_blank_n === 1'b1 && {vga_r, vga_g, vga_b} === 24'hFFFFFF) white++;
        end
        checks++;
        if (white !== 2 * HA * VA) begin
            failures++;
            $display("FAIL white_cycles: got %0d, expected %0d", white, 2 * HA * VA);
        end
        all_ones_mode = 1'b0;
        $display("test_blank_forcing done: checks=%0d", checks);
    endtask

    task automatic test_mid_reset();
        int guard, p, q, h, v;
        logic eb, ehs, evs;
        logic [7:0] er;
        guard = 0;
        // Counters at (10, 5) after the tick that consumed (9, 5).
        while (!(((tick_n % FRAME_TICKS) == 5 * HT + 10) && !tb_tick)) begin
            @(negedge clk);
            guard++;
            if (guard > FRAME_CLK + 8) break;
        end
        checks++;
        if (guard > FRAME_CLK + 8 || fb_rden !== 1'b1 || fb_rdaddress !== 17'd20) begin
            failures++;
            $display("FAIL pre_reset_pos: got rden=%0b addr=%0d guard=%0d, expected rden=1 addr=20", fb_rden, fb_rdaddress, guard);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_rden, fb_rdaddress, vga_r, vga_g, vga_b} !== {1'b0, 17'd0, 24'h0}) begin
            failures++;
            $display("FAIL midreset_data: got rden=%0b addr=%0d colour=%h%h%h, expected 0 0 000000",
                     fb_rden, fb_rdaddress, vga_r, vga_g, vga_b);
        end
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start} !== 5'b11000) begin
            failures++;
            $display("FAIL midreset_ctrl: got hs,vs,blank_n,clk,fs=%b, expected 11000",
                     {vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * (FRAME_TICKS + 2 * HT); c++) begin
            @(negedge clk);
            p = tick_n - 1;
            q = p - D;
            h = (q >= 0) ? pos_h(q) : 0;
            v = (q >= 0) ? pos_v(q) : 0;
            eb  = pos_active(q);
            ehs = (q < 0) || !(h >= HA + HF && h < HA + HF + HS);
            evs = (q < 0) || !(v >= VA + VF && v < VA + VF + VS);
            er  = eb ? 8'(pix_addr(h, v)) : 8'h00;
            checks++;
            if (fb_rden !== pos_active(p) || fb_rdaddress !== AW'(held_addr(p))) begin
                failures++;
                $display("FAIL restart_addr p=%0d: got rden=%0b addr=%0d, expected rden=%0b addr=%0d",
                         p, fb_rden, fb_rdaddress, pos_active(p), held_addr(p));
            end
            checks++;
            if ({vga_blank_n, vga_hs, vga_vs, vga_r} !== {eb, ehs, evs, er}) begin
                failures++;
                $display("FAIL restart_pins q=%0d: got blank_n,hs,vs=%b r=%h, expected %b r=%h",
                         q, {vga_blank_n, vga_hs, vga_vs}, vga_r, {eb, ehs, evs}, er);
            end
        end
        $display("test_mid_reset done: checks=%0d", checks);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_address();
        test_pixels();
        test_sync_timing();
        test_blank_forcing();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
